// File: rtl/mvm_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_host_pkg
//  Purpose  : Shared types and constants for the MVM host sequencer. Holds the
//             sequencer state encoding, the default dimensions and the derived
//             counter widths for those defaults.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mvm_host_pkg;

    localparam int K_DEF        = 32;
    localparam int DONE_TMO_DEF = 4096;

    // Counter widths for the default configuration. The top level re-derives
    // them from its own parameters so that overridden sizes stay consistent.
    localparam int AW = $clog2(K_DEF * K_DEF);
    localparam int VW = $clog2(K_DEF);
    localparam int CW = $clog2(DONE_TMO_DEF);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_M    = 4'd1,
        ST_PULSE_M   = 4'd2,
        ST_BURST_M   = 4'd3,
        ST_GAP_M     = 4'd4,
        ST_WAIT_V    = 4'd5,
        ST_PULSE_V   = 4'd6,
        ST_BURST_V   = 4'd7,
        ST_GAP_V     = 4'd8,
        ST_START     = 4'd9,
        ST_WAIT_DONE = 4'd10,
        ST_LAT       = 4'd11,
        ST_CAPTURE   = 4'd12
    } state_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_stream_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO with occupancy count.
//             A push while full is refused even if a pop happens in the same
//             cycle; a pop while empty is ignored.
//  Ports    : clk, reset (async, active-low)
//             push/push_data  - write side
//             pop/pop_data    - read side, pop_data shows the head entry
//             count/full/empty - occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module mvm_stream_fifo
    import mvm_host_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mvm_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_host_sequencer
//  Purpose  : Host-side driver for the serial MVM engine. Buffers an input
//             element stream, replays it to the engine as gapless matrix and
//             vector bursts, starts the engine, captures the K-element result
//             burst and drains it over valid/ready.
//  Ports    : clk, reset (async, active-low)
//             job_go/job_reuse_mat          - job request (ignored while busy)
//             in_data/in_valid/in_ready     - operand input stream
//             mvm_loadMatrix/loadVector/start, mvm_data_in  - engine controls
//             mvm_done, mvm_data_out        - engine completion and results
//             res_data/res_valid/res_ready/res_last - result output stream
//             busy, err_underrun, err_timeout, err_clear - status
//  Revision : 1.0  initial release
// ============================================================================
module mvm_host_sequencer
    import mvm_host_pkg::*;
#(
    parameter int K           = K_DEF,
    parameter int B           = 8,
    parameter int IN_DEPTH    = 64,
    parameter int FILL_THRESH = 32,
    parameter int OUT_LAT     = 2,
    parameter int DONE_TMO    = DONE_TMO_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           job_go,
    input  logic           job_reuse_mat,
    input  logic [B-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           mvm_loadMatrix,
    output logic           mvm_loadVector,
    output logic           mvm_start,
    output logic [B-1:0]   mvm_data_in,
    input  logic           mvm_done,
    input  logic [2*B-1:0] mvm_data_out,
    output logic [2*B-1:0] res_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_last,
    output logic           busy,
    output logic           err_underrun,
    output logic           err_timeout,
    input  logic           err_clear
);

    localparam int ELEM_W   = $clog2(K * K) + 1;
    localparam int TMO_W    = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;
    localparam int IN_CW    = $clog2(IN_DEPTH) + 1;
    localparam int RES_CW   = $clog2(K) + 1;
    localparam int RIDX_W   = (K > 1) ? $clog2(K) : 1;
    localparam int MAT_FILL = min_int(FILL_THRESH, K * K);
    localparam int VEC_FILL = min_int(FILL_THRESH, K);
    // LAT is held OUT_LAT-1 cycles; the counter starts at 0 on entry.
    localparam int LAT_LAST = (OUT_LAT >= 2) ? OUT_LAT - 2 : 0;

    state_t              state;
    state_t              state_next;
    logic [ELEM_W-1:0]   elem_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [RIDX_W-1:0]   res_idx;
    logic                ready_en;
    logic                in_burst;

    logic                in_push;
    logic                in_pop;
    logic [B-1:0]        in_head;
    logic [IN_CW-1:0]    in_count;
    logic                in_full;
    logic                in_empty;

    logic                res_push;
    logic                res_pop;
    logic [2*B-1:0]      res_head;
    logic [RES_CW-1:0]   res_count;
    logic                res_full;
    logic                res_empty;

    // in_ready stays low until the first clock after reset is released so
    // that every output reads 0 while reset is held.
    assign in_ready  = ready_en & ~in_full;
    assign in_push   = in_valid & in_ready;
    assign in_burst  = (state == ST_BURST_M) || (state == ST_BURST_V);

    assign res_valid = ~res_empty;
    assign res_data  = res_empty ? '0 : res_head;
    assign res_pop   = res_valid & res_ready;
    assign res_last  = res_valid && (res_idx == RIDX_W'(K - 1));
    assign busy      = (state != ST_IDLE) || (res_count != '0);

    mvm_stream_fifo #(
        .W     (B),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_push),
        .push_data (in_data),
        .pop       (in_pop),
        .pop_data  (in_head),
        .count     (in_count),
        .full      (in_full),
        .empty     (in_empty)
    );

    mvm_stream_fifo #(
        .W     (2 * B),
        .DEPTH (K)
    ) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (res_push),
        .push_data (mvm_data_out),
        .pop       (res_pop),
        .pop_data  (res_head),
        .count     (res_count),
        .full      (res_full),
        .empty     (res_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        mvm_loadMatrix = 1'b0;
        mvm_loadVector = 1'b0;
        mvm_start      = 1'b0;
        mvm_data_in    = '0;
        in_pop         = 1'b0;
        res_push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (job_go && !busy) begin
                    state_next = job_reuse_mat ? ST_WAIT_V : ST_WAIT_M;
                end
            end
            ST_WAIT_M: begin
                if (in_count >= IN_CW'(MAT_FILL)) state_next = ST_PULSE_M;
            end
            ST_PULSE_M: begin
                mvm_loadMatrix = 1'b1;
                state_next     = ST_BURST_M;
            end
            ST_BURST_M: begin
                // An empty FIFO yields a zero element; the burst length is fixed.
                in_pop      = ~in_empty;
                mvm_data_in = in_empty ? '0 : in_head;
                if (elem_cnt == ELEM_W'(K * K - 1)) state_next = ST_GAP_M;
            end
            ST_GAP_M: begin
                state_next = ST_WAIT_V;
            end
            ST_WAIT_V: begin
                if (in_count >= IN_CW'(VEC_FILL)) state_next = ST_PULSE_V;
            end
            ST_PULSE_V: begin
                mvm_loadVector = 1'b1;
                state_next     = ST_BURST_V;
            end
            ST_BURST_V: begin
                in_pop      = ~in_empty;
                mvm_data_in = in_empty ? '0 : in_head;
                if (elem_cnt == ELEM_W'(K - 1)) state_next = ST_GAP_V;
            end
            ST_GAP_V: begin
                state_next = ST_START;
            end
            ST_START: begin
                mvm_start  = 1'b1;
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving on the final timeout cycle still wins.
                if (mvm_done) begin
                    state_next = (OUT_LAT <= 1) ? ST_CAPTURE : ST_LAT;
                end else if (tmo_cnt == TMO_W'(DONE_TMO - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_LAT: begin
                if (elem_cnt == ELEM_W'(LAT_LAST)) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_push = ~res_full;
                if (elem_cnt == ELEM_W'(K - 1)) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Shared element/latency counter: restarts at every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elem_cnt <= '0;
        end else if (state_next != state) begin
            elem_cnt <= '0;
        end else if (in_burst || (state == ST_LAT) || (state == ST_CAPTURE)) begin
            elem_cnt <= elem_cnt + ELEM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == ST_START) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Position of the next popped result within its job, for res_last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_idx <= '0;
        end else if (res_pop) begin
            res_idx <= (res_idx == RIDX_W'(K - 1)) ? '0 : res_idx + RIDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en     <= 1'b0;
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (err_clear) begin
                err_underrun <= 1'b0;
            end else if (in_burst && in_empty) begin
                err_underrun <= 1'b1;
            end
            if (err_clear) begin
                err_timeout <= 1'b0;
            end else if ((state == ST_WAIT_DONE) && !mvm_done &&
                         (tmo_cnt == TMO_W'(DONE_TMO - 1))) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mvm_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mvm_host_sequencer
//  Purpose  : Directed self-checking bench for mvm_host_sequencer with a small
//             behavioural MVM engine, an input feeder and a result monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mvm_host_sequencer;

    localparam int K        = 32;
    localparam int B        = 8;
    localparam int OUT_LAT  = 2;
    localparam int DONE_TMO = 4096;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           job_go = 1'b0;
    logic           job_reuse_mat = 1'b0;
    logic [B-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           mvm_loadMatrix;
    logic           mvm_loadVector;
    logic           mvm_start;
    logic [B-1:0]   mvm_data_in;
    logic           mvm_done = 1'b0;
    logic [2*B-1:0] mvm_data_out = '0;
    logic [2*B-1:0] res_data;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic           res_last;
    logic           busy;
    logic           err_underrun;
    logic           err_timeout;
    logic           err_clear = 1'b0;

    mvm_host_sequencer #(
        .K           (K),
        .B           (B),
        .IN_DEPTH    (64),
        .FILL_THRESH (32),
        .OUT_LAT     (OUT_LAT),
        .DONE_TMO    (DONE_TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .job_go         (job_go),
        .job_reuse_mat  (job_reuse_mat),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mvm_loadMatrix (mvm_loadMatrix),
        .mvm_loadVector (mvm_loadVector),
        .mvm_start      (mvm_start),
        .mvm_data_in    (mvm_data_in),
        .mvm_done       (mvm_done),
        .mvm_data_out   (mvm_data_out),
        .res_data       (res_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_last       (res_last),
        .busy           (busy),
        .err_underrun   (err_underrun),
        .err_timeout    (err_timeout),
        .err_clear      (err_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- input feeder ----------------
    logic [B-1:0] feed_q[$];

    always begin
        @(posedge clk); #1;
        if (reset && (feed_q.size() > 0) && in_ready) begin
            in_valid = 1'b1;
            in_data  = feed_q.pop_front();
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
    end

    // ---------------- engine model ----------------
    int                   cyc = 0;
    int                   n_lm = 0, n_lv = 0, n_start = 0;
    int                   m_off = 0, v_off = 0, m_zeros = 0;
    bit                   m_act = 0, v_act = 0, done_en = 1;
    int                   done_at = -1000, start_cyc = 0;
    logic [B-1:0]         m_last_el = '0, m_gap_el = '1;
    logic signed [B-1:0]  mat [K][K];
    logic signed [B-1:0]  vec [K];
    logic [2*B-1:0]       y_mdl [K];
    int                   acc;

    always begin
        @(posedge clk); #1;
        cyc++;
        mvm_done     = 1'b0;
        mvm_data_out = 16'hDEAD;
        if (!reset) begin
            m_act   = 0;
            v_act   = 0;
            done_at = -1000;
        end else begin
            if (m_act) begin
                m_off++;
                if (m_off <= K * K) begin
                    mat[(m_off - 1) / K][(m_off - 1) % K] = mvm_data_in;
                    if (mvm_data_in == '0) m_zeros++;
                    if (m_off == K * K) m_last_el = mvm_data_in;
                end else begin
                    m_gap_el = mvm_data_in;
                    m_act    = 0;
                end
            end
            if (v_act) begin
                v_off++;
                if (v_off <= K) vec[v_off - 1] = mvm_data_in;
                else v_act = 0;
            end
            if (mvm_loadMatrix) begin
                n_lm++; m_act = 1; m_off = 0; m_zeros = 0;
            end
            if (mvm_loadVector) begin
                n_lv++; v_act = 1; v_off = 0;
            end
            if (mvm_start) begin
                n_start++;
                start_cyc = cyc;
                for (int r = 0; r < K; r++) begin
                    acc = 0;
                    for (int c = 0; c < K; c++) acc += int'(mat[r][c]) * int'(vec[c]);
                    y_mdl[r] = acc[2*B-1:0];
                end
                done_at = done_en ? cyc + 3 : -1000;
            end
            if (cyc == done_at) mvm_done = 1'b1;
            if ((done_at >= 0) && (cyc >= done_at + OUT_LAT) && (cyc < done_at + OUT_LAT + K))
                mvm_data_out = y_mdl[cyc - done_at - OUT_LAT];
        end
    end

    // ---------------- result monitor ----------------
    logic [2*B-1:0] res_q[$];
    bit             last_q[$];

    always @(negedge clk) begin
        if (reset && res_valid && res_ready) begin
            res_q.push_back(res_data);
            last_q.push_back(res_last);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic pulse_go(input bit reuse);
        job_reuse_mat = reuse;
        job_go        = 1'b1;
        tick();
        job_go        = 1'b0;
        job_reuse_mat = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        tick();
    endtask

    task automatic wait_res(input int n, input int budget, input string tag);
        int k = 0;
        while ((res_q.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
        check(tag, res_q.size(), n);
    endtask

    task automatic check_results(input string tag, input logic [2*B-1:0] base, input bit ramp);
        int bad = 0, lasts = 0;
        for (int i = 0; i < K; i++) begin
            if (res_q[i] !== (ramp ? (2*B)'(i) : base)) bad++;
            if (last_q[i]) lasts++;
        end
        check({tag, "_values"}, bad, 0);
        check({tag, "_last_cnt"}, lasts, 1);
        check({tag, "_last_pos"}, last_q[K-1], 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int lm0, lv0, st0, k, bad, s;

    initial begin
        // ---- reset state ----
        repeat (3) tick();
        check("rst_ctrl", {in_ready, mvm_loadMatrix, mvm_loadVector, mvm_start, res_valid,
                           res_last, busy, err_underrun, err_timeout}, 0);
        check("rst_data_in", mvm_data_in, 0);
        check("rst_res_data", res_data, 0);
        reset = 1'b1;
        repeat (2) tick();
        check("ready_after_rst", in_ready, 1);

        // ---- job 1: A = identity, x[i] = i ----
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) feed_q.push_back((r == c) ? 8'd1 : 8'd0);
        for (int i = 0; i < K; i++) feed_q.push_back(B'(i));
        pulse_go(0);
        wait_res(K, 3000, "job1_results");
        check("job1_loadm", n_lm, 1);
        check("job1_loadv", n_lv, 1);
        check("job1_start", n_start, 1);
        bad = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                if (mat[r][c] !== ((r == c) ? 8'sd1 : 8'sd0)) bad++;
        check("job1_mat_stream", bad, 0);
        bad = 0;
        for (int i = 0; i < K; i++) if (vec[i] !== B'(i)) bad++;
        check("job1_vec_stream", bad, 0);
        check("job1_mat_gap", m_gap_el, 0);
        check("job1_y0", res_q[0], 16'd0);
        check("job1_y31", res_q[K-1], 16'd31);
        check_results("job1", 16'd0, 1);
        check("job1_idle", busy, 0);

        // ---- job 2: reuse A, x = -2, results held back ----
        res_q.delete(); last_q.delete();
        lm0 = n_lm; lv0 = n_lv; st0 = n_start;
        res_ready = 1'b0;
        repeat (K) feed_q.push_back(8'hFE);
        pulse_go(1);
        k = 0;
        while ((n_start == st0) && (k < 500)) begin tick(); k++; end
        check("job2_started", n_start, st0 + 1);
        repeat (60) tick();
        check("job2_held_valid", res_valid, 1);
        check("job2_busy_held", busy, 1);
        repeat (K) feed_q.push_back(8'h07);
        pulse_go(1);
        repeat (100) tick();
        check("job2_go_ignored", n_lv, lv0 + 1);
        check("job2_no_loadm", n_lm, lm0);
        check("job2_none_popped", res_q.size(), 0);
        res_ready = 1'b1;
        wait_res(K, 200, "job2_results");
        check_results("job2", 16'hFFFE, 0);

        // ---- timeout: engine never signals done ----
        done_en = 0;
        st0 = n_start;
        pulse_go(1);
        k = 0;
        while ((n_start == st0) && (k < 200)) begin tick(); k++; end
        check("tmo_started", n_start, st0 + 1);
        s = start_cyc;
        while (cyc < s + DONE_TMO - 1) tick();
        check("tmo_not_early", err_timeout, 0);
        while (cyc < s + DONE_TMO + 2) tick();
        check("tmo_flag", err_timeout, 1);
        check("tmo_idle", busy, 0);
        check("tmo_no_results", res_valid, 0);
        pulse_clear();
        check("tmo_cleared", err_timeout, 0);
        done_en = 1;

        // ---- underrun: input starved mid matrix burst ----
        res_q.delete(); last_q.delete();
        lm0 = n_lm;
        repeat (40) feed_q.push_back(8'd3);
        pulse_go(0);
        k = 0;
        while (!(m_act && (m_off >= 40)) && (k < 500)) begin tick(); k++; end
        check("udr_reached_40", (m_off >= 40), 1);
        repeat (5) tick();
        repeat (K * K - 40) feed_q.push_back(8'd3);
        repeat (K) feed_q.push_back(8'd1);
        wait_res(K, 3000, "udr_results");
        check("udr_flag", err_underrun, 1);
        check("udr_zero_run", ((m_zeros >= 5) && (m_zeros <= 8)), 1);
        check("udr_last_elem", m_last_el, 3);
        check("udr_gap_zero", m_gap_el, 0);
        check("udr_one_loadm", n_lm, lm0 + 1);
        pulse_clear();
        check("udr_cleared", err_underrun, 0);

        // ---- asynchronous reset mid vector burst ----
        res_q.delete(); last_q.delete();
        repeat (K) feed_q.push_back(8'h05);
        pulse_go(1);
        k = 0;
        while (!(v_act && (v_off >= 10)) && (k < 500)) begin tick(); k++; end
        check("arst_in_vburst", (v_off >= 10), 1);
        feed_q.delete();
        check("arst_pre_data", (mvm_data_in != '0), 1);
        #1 reset = 1'b0;
        #1;
        check("arst_ctrl", {in_ready, mvm_loadMatrix, mvm_loadVector, mvm_start, res_valid,
                            res_last, busy, err_underrun, err_timeout}, 0);
        check("arst_data_in", mvm_data_in, 0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        check("arst_ready_back", in_ready, 1);
        check("arst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
